pifo_calendar_ctrl: RTL and testbench

PIFO_CALENDAR_CTRL -- requirements
Module: pifo_calendar_ctrl

---
 rtl/pifo_calendar_ctrl_pkg.sv | 16 +
 rtl/pifo_occupancy_counter.sv | 39 +++
 rtl/pifo_calendar_ctrl.sv | 108 ++++++++++
 tb/tb_pifo_calendar_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_calendar_ctrl_pkg.sv
// Shared definitions for the PIFO calendar controller and the array atoms it drives.
// Holds the controller state encoding and the element field layout.
package pifo_calendar_ctrl_pkg;

   typedef enum logic [0:0] {
      StRun   = 1'b0,
      StFlush = 1'b1
   } state_e;

   localparam int unsigned DefElementWidth  = 32;
   localparam int unsigned DefInfoValidPos  = 31;
   // Rank occupies the low bits; lower rank dequeues first.
   localparam int unsigned RankLsb          = 0;
   localparam int unsigned RankWidth        = 16;

endpackage

// File: rtl/pifo_occupancy_counter.sv
// Up/down occupancy counter that saturates at 0 and DEPTH, with full/empty flags.
module pifo_occupancy_counter #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] count_q, count_d;

   assign full  = (count_q == WIDTH'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   // Simultaneous inc and dec leave the count unchanged.
   always_comb begin
      count_d = count_q;
      if (inc && !dec && !full) begin
         count_d = count_q + WIDTH'(1);
      end else if (dec && !inc && !empty) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pifo_calendar_ctrl.sv
// Controller for a systolic PIFO array: handshakes inserts/pops, broadcasts array
// controls, tracks occupancy and drains the array on flush.
module pifo_calendar_ctrl
   import pifo_calendar_ctrl_pkg::*;
#(
   parameter int unsigned ELEMENT_WIDTH       = DefElementWidth,
   parameter int unsigned PIFO_DEPTH          = 16,
   parameter int unsigned COUNT_WIDTH         = 5,
   parameter int unsigned PIFO_INFO_VALID_POS = DefInfoValidPos
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [ELEMENT_WIDTH-1:0] s_insert_data,
   input  logic                     s_insert_valid,
   output logic                     s_insert_ready,
   input  logic                     s_pop_valid,
   output logic                     s_pop_ready,
   output logic [ELEMENT_WIDTH-1:0] m_pop_data,
   output logic                     m_pop_valid,
   input  logic                     in_flush,
   output logic                     out_ctl_insert,
   output logic                     out_ctl_pop,
   output logic [ELEMENT_WIDTH-1:0] out_pifo_input,
   input  logic [ELEMENT_WIDTH-1:0] in_pifo_head,
   output logic [COUNT_WIDTH-1:0]   out_count,
   output logic                     out_full,
   output logic                     out_empty
);

   state_e                   state_q, state_d;
   logic                     pop_fire, insert_fire;
   logic [ELEMENT_WIDTH-1:0] pop_data_q;
   logic                     pop_valid_q;

   pifo_occupancy_counter #(
      .DEPTH (PIFO_DEPTH),
      .WIDTH (COUNT_WIDTH)
   ) u_occupancy (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (out_ctl_insert),
      .dec   (out_ctl_pop),
      .count (out_count),
      .full  (out_full),
      .empty (out_empty)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:   if (in_flush) state_d = StFlush;
         StFlush: if (out_empty && !in_flush) state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   // Everything is gated by rstn so no handshake or control leaks during reset.
   always_comb begin
      s_pop_ready    = 1'b0;
      s_insert_ready = 1'b0;
      pop_fire       = 1'b0;
      insert_fire    = 1'b0;
      out_ctl_pop    = 1'b0;
      out_ctl_insert = 1'b0;
      out_pifo_input = '0;
      if (rstn) begin
         unique case (state_q)
            StRun: begin
               s_pop_ready    = ~out_empty;
               pop_fire       = s_pop_valid & ~out_empty;
               s_insert_ready = ~out_full | pop_fire;
               insert_fire    = s_insert_valid & s_insert_ready;
               out_ctl_pop    = pop_fire;
               out_ctl_insert = insert_fire;
               if (insert_fire) begin
                  out_pifo_input                      = s_insert_data;
                  out_pifo_input[PIFO_INFO_VALID_POS] = 1'b1;
               end
            end
            StFlush: out_ctl_pop = ~out_empty;
            default: ;
         endcase
      end
   end

   // Head is sampled at the pop edge, so a same-cycle insert never affects it.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pop_valid_q <= 1'b0;
         pop_data_q  <= '0;
      end else begin
         pop_valid_q <= pop_fire;
         if (pop_fire) pop_data_q <= in_pifo_head;
      end
   end

   assign m_pop_valid = pop_valid_q;
   assign m_pop_data  = pop_data_q;

endmodule

// File: tb/tb_pifo_calendar_ctrl.sv
// Bench for pifo_calendar_ctrl: a sorted-queue array stand-in, a queue-based reference
// checked every cycle, and directed scenarios with literal expectations.
module tb_pifo_calendar_ctrl;
   import pifo_calendar_ctrl_pkg::*;

   localparam int unsigned W     = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned CW    = 5;
   localparam int unsigned VPOS  = 31;

   logic          clk = 1'b0;
   logic          rstn;
   logic [W-1:0]  s_insert_data;
   logic          s_insert_valid;
   logic          s_insert_ready;
   logic          s_pop_valid;
   logic          s_pop_ready;
   logic [W-1:0]  m_pop_data;
   logic          m_pop_valid;
   logic          in_flush;
   logic          out_ctl_insert;
   logic          out_ctl_pop;
   logic [W-1:0]  out_pifo_input;
   logic [W-1:0]  in_pifo_head = '0;
   logic [CW-1:0] out_count;
   logic          out_full;
   logic          out_empty;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pifo_calendar_ctrl #(
      .ELEMENT_WIDTH       (W),
      .PIFO_DEPTH          (DEPTH),
      .COUNT_WIDTH         (CW),
      .PIFO_INFO_VALID_POS (VPOS)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .s_insert_data  (s_insert_data),
      .s_insert_valid (s_insert_valid),
      .s_insert_ready (s_insert_ready),
      .s_pop_valid    (s_pop_valid),
      .s_pop_ready    (s_pop_ready),
      .m_pop_data     (m_pop_data),
      .m_pop_valid    (m_pop_valid),
      .in_flush       (in_flush),
      .out_ctl_insert (out_ctl_insert),
      .out_ctl_pop    (out_ctl_pop),
      .out_pifo_input (out_pifo_input),
      .in_pifo_head   (in_pifo_head),
      .out_count      (out_count),
      .out_full       (out_full),
      .out_empty      (out_empty)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] elem(input logic [15:0] r);
      logic [W-1:0] e;
      e                          = '0;
      e[RankLsb +: RankWidth]    = r;
      e[30:16]                   = r[14:0] ^ 15'h2a5;
      return e;
   endfunction

   // Position after all entries of equal or lower rank.
   function automatic int ins_pos(input logic [W-1:0] q[$], input logic [W-1:0] e);
      int p = 0;
      while (p < q.size() && q[p][RankLsb +: RankWidth] <= e[RankLsb +: RankWidth]) p++;
      return p;
   endfunction

   // Array stand-in: reacts only to the broadcast controls.
   logic [W-1:0] arr[$];
   always @(posedge clk) begin
      if (!rstn) begin
         arr.delete();
      end else begin
         if (out_ctl_pop && arr.size() > 0) void'(arr.pop_front());
         if (out_ctl_insert) arr.insert(ins_pos(arr, out_pifo_input), out_pifo_input);
      end
      in_pifo_head <= (arr.size() > 0) ? arr[0] : '0;
   end

   // Reference: sorted contents, mode, and the expected registered pop outputs.
   logic [W-1:0] mq[$];
   logic         m_flush = 1'b0;
   logic         mpv     = 1'b0;
   logic [W-1:0] mpd     = '0;

   always @(negedge clk) begin
      logic         e_pr, e_ir, pf, inf, e_cp;
      logic [W-1:0] e_in;
      e_pr = 1'b0; e_ir = 1'b0; pf = 1'b0; inf = 1'b0; e_cp = 1'b0; e_in = '0;
      if (rstn) begin
         if (!m_flush) begin
            e_pr = (mq.size() > 0);
            pf   = s_pop_valid & e_pr;
            e_ir = (mq.size() < DEPTH) | pf;
            inf  = s_insert_valid & e_ir;
            e_cp = pf;
            if (inf) begin
               e_in       = s_insert_data;
               e_in[VPOS] = 1'b1;
            end
         end else begin
            e_cp = (mq.size() > 0);
         end
      end
      chk("pop_ready",   s_pop_ready,    e_pr);
      chk("ins_ready",   s_insert_ready, e_ir);
      chk("ctl_pop",     out_ctl_pop,    e_cp);
      chk("ctl_insert",  out_ctl_insert, inf);
      chk("pifo_input",  out_pifo_input, e_in);
      chk("count",       out_count,      mq.size());
      chk("full",        out_full,       mq.size() == DEPTH);
      chk("empty",       out_empty,      mq.size() == 0);
      chk("m_pop_valid", m_pop_valid,    mpv);
      chk("m_pop_data",  m_pop_data,     mpd);
      if (!rstn) begin
         mq.delete();
         m_flush = 1'b0;
         mpv     = 1'b0;
         mpd     = '0;
      end else begin
         mpv = pf;
         if (pf) mpd = mq[0];
         if (m_flush && mq.size() == 0 && !in_flush) m_flush = 1'b0;
         else if (!m_flush && in_flush) m_flush = 1'b1;
         if (e_cp) void'(mq.pop_front());
         if (inf) mq.insert(ins_pos(mq, e_in), e_in);
      end
   end

   task automatic set(input logic iv, input logic [15:0] r, input logic pv, input logic fl);
      s_insert_valid = iv;
      s_insert_data  = elem(r);
      s_pop_valid    = pv;
      in_flush       = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [15:0] r, input logic pv, input logic fl);
      set(iv, r, pv, fl);
      step();
   endtask

   initial begin
      int exp38[3];
      int pops, vals;
      exp38 = '{3, 5, 9};
      rstn  = 1'b0;
      set(1'b1, 16'd5, 1'b1, 1'b0);
      repeat (2) step();
      chk("rst_ins_ready", s_insert_ready, 1'b0);
      chk("rst_ctl_insert", out_ctl_insert, 1'b0);
      chk("rst_count", out_count, 0);
      chk("rst_valid", m_pop_valid, 1'b0);
      chk("rst_data", m_pop_data, 0);
      chk("rst_empty", out_empty, 1'b1);
      set(1'b0, 16'd0, 1'b0, 1'b0);
      rstn = 1'b1;
      #1;

      // Ordering 5,3,9 -> 3,5,9 with latency 1.
      drive(1'b1, 16'd5, 1'b0, 1'b0);
      drive(1'b1, 16'd3, 1'b0, 1'b0);
      drive(1'b1, 16'd9, 1'b0, 1'b0);
      chk("ord_count3", out_count, 3);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 16'd0, 1'b1, 1'b0);
         chk("ord_valid", m_pop_valid, 1'b1);
         chk("ord_rank", m_pop_data[15:0], exp38[i]);
         chk("ord_vbit", m_pop_data[VPOS], 1'b1);
      end
      drive(1'b0, 16'd0, 1'b0, 1'b0);
      chk("ord_count0", out_count, 0);
      chk("ord_valid_drop", m_pop_valid, 1'b0);

      // Pop on empty.
      set(1'b0, 16'd0, 1'b1, 1'b0);
      #1;
      chk("empty_pop_ready", s_pop_ready, 1'b0);
      chk("empty_ctl_pop", out_ctl_pop, 1'b0);
      step();
      chk("empty_pop_valid", m_pop_valid, 1'b0);

      // Fill to full, blocked insert, then insert with pop.
      for (int i = 0; i < 16; i++) drive(1'b1, 16'(10 + ((i * 7) % 16)), 1'b0, 1'b0);
      chk("full_count", out_count, 16);
      chk("full_flag", out_full, 1'b1);
      set(1'b1, 16'd1, 1'b0, 1'b0);
      #1;
      chk("full_ins_ready", s_insert_ready, 1'b0);
      chk("full_ctl_insert", out_ctl_insert, 1'b0);
      step();
      chk("full_count_hold", out_count, 16);
      set(1'b1, 16'd1, 1'b1, 1'b0);
      #1;
      chk("full_ins_pop_ready", s_insert_ready, 1'b1);
      step();
      chk("full_swap_count", out_count, 16);
      chk("full_swap_rank", m_pop_data[15:0], 10);
      drive(1'b0, 16'd0, 1'b0, 1'b1);
      repeat (18) drive(1'b0, 16'd0, 1'b0, 1'b0);
      chk("drain_count", out_count, 0);

      // Same-cycle insert and pop returns the old head.
      drive(1'b1, 16'd4, 1'b0, 1'b0);
      drive(1'b1, 16'd2, 1'b1, 1'b0);
      chk("swap_rank4", m_pop_data[15:0], 4);
      chk("swap_count", out_count, 1);
      drive(1'b0, 16'd0, 1'b1, 1'b0);
      chk("swap_rank2", m_pop_data[15:0], 2);

      // Flush 7 entries.
      for (int i = 0; i < 7; i++) drive(1'b1, 16'(20 + i), 1'b0, 1'b0);
      drive(1'b0, 16'd0, 1'b0, 1'b1);
      pops = 0;
      vals = 0;
      for (int k = 0; k < 20; k++) begin
         set(1'b0, 16'd0, 1'b0, 1'b0);
         #1;
         if (out_ctl_pop) pops++;
         step();
         if (m_pop_valid) vals++;
      end
      chk("flush_pops", pops, 7);
      chk("flush_vals", vals, 0);
      chk("flush_count", out_count, 0);
      set(1'b1, 16'd7, 1'b0, 1'b0);
      #1;
      chk("flush_back_run", s_insert_ready, 1'b1);
      step();
      drive(1'b0, 16'd0, 1'b1, 1'b0);

      // Flush raised alongside a pop: the pop still completes.
      drive(1'b1, 16'd8, 1'b0, 1'b0);
      drive(1'b1, 16'd6, 1'b0, 1'b0);
      drive(1'b0, 16'd0, 1'b1, 1'b1);
      chk("flushpop_valid", m_pop_valid, 1'b1);
      chk("flushpop_rank", m_pop_data[15:0], 6);
      set(1'b0, 16'd0, 1'b0, 1'b0);
      #1;
      chk("flushpop_ins_ready", s_insert_ready, 1'b0);
      chk("flushpop_ctl_pop", out_ctl_pop, 1'b1);
      repeat (4) step();
      chk("flushpop_count", out_count, 0);

      // Reset mid-flush with 3 left.
      for (int i = 0; i < 5; i++) drive(1'b1, 16'(30 + i), 1'b0, 1'b0);
      drive(1'b0, 16'd0, 1'b0, 1'b1);
      repeat (2) drive(1'b0, 16'd0, 1'b0, 1'b0);
      chk("rstflush_count3", out_count, 3);
      rstn = 1'b0;
      step();
      chk("rstflush_count0", out_count, 0);
      chk("rstflush_valid", m_pop_valid, 1'b0);
      chk("rstflush_data", m_pop_data, 0);
      rstn = 1'b1;
      #1;
      chk("rstflush_run", s_insert_ready, 1'b1);

      // Reset right after a pop fires.
      drive(1'b1, 16'd11, 1'b0, 1'b0);
      drive(1'b0, 16'd0, 1'b1, 1'b0);
      chk("rstpop_valid_pre", m_pop_valid, 1'b1);
      rstn = 1'b0;
      step();
      chk("rstpop_valid", m_pop_valid, 1'b0);
      rstn = 1'b1;
      step();
      chk("rstpop_valid_post", m_pop_valid, 1'b0);
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
